// File: rtl/ccm_coeff_ctrl.sv
// rtl/ccm_coeff_ctrl.sv - colour-correction coefficient controller; optional readback port under CCM_READBACK_EN
module ccm_coeff_ctrl #(
    parameter int INT_BITS  = 6,
    parameter int FRAC_BITS = 6,
    localparam int W        = INT_BITS + FRAC_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [W-1:0]        wr_data,
    input  logic                commit,
    input  logic                frame_start,
    input  logic                preset_load,
    input  logic [1:0]          preset_sel,
    output logic [8:0][W-1:0]   cc_coeff,
    output logic                busy,
    output logic                pending,
    output logic                swap_done,
    output logic                wr_err
`ifdef CCM_READBACK_EN
    ,
    input  logic [3:0]          rd_addr,
    output logic [W-1:0]        rd_data
`endif
);

    // Fixed-point constants: 1.0 and BT.601 luma weights rounded to FRAC_BITS
    localparam logic [W-1:0] ONE    = W'(1 << FRAC_BITS);
    localparam logic [W-1:0] GRAY_R = W'((299 * (1 << FRAC_BITS) + 500) / 1000);
    localparam logic [W-1:0] GRAY_G = W'((587 * (1 << FRAC_BITS) + 500) / 1000);
    localparam logic [W-1:0] GRAY_B = W'((114 * (1 << FRAC_BITS) + 500) / 1000);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRELOAD = 2'd1,
        S_ARMED   = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               commit_latched, latch_next;
    logic [3:0]         cnt, cnt_next;
    logic [1:0]         sel_q, sel_next;
    logic               do_swap;
    logic               do_wr;
    logic               wr_reject;
    logic [8:0][W-1:0]  shadow;

    // Built-in matrices; index order follows cc_coeff (3r+2 red, 3r+1 green, 3r blue)
    function automatic logic [W-1:0] preset_word(input logic [1:0] sel, input logic [3:0] idx);
        logic [W-1:0] word;
        word = '0;
        case (sel)
            2'd0: begin
                if (idx == 4'd2 || idx == 4'd4 || idx == 4'd6)
                    word = ONE;
            end
            2'd1: begin
                case (idx)
                    4'd0, 4'd3, 4'd6: word = GRAY_B;
                    4'd1, 4'd4, 4'd7: word = GRAY_G;
                    4'd2, 4'd5, 4'd8: word = GRAY_R;
                    default:          word = '0;
                endcase
            end
            2'd2: begin
                if (idx == 4'd0 || idx == 4'd4 || idx == 4'd8)
                    word = ONE;
            end
            default: word = '0;
        endcase
        return word;
    endfunction

    // Control state register: FSM state, latched commit, preload counter and preset index
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            commit_latched <= 1'b0;
            cnt            <= 4'd0;
            sel_q          <= 2'd0;
        end else begin
            state          <= state_next;
            commit_latched <= latch_next;
            cnt            <= cnt_next;
            sel_q          <= sel_next;
        end
    end

    // Next-state logic plus write acceptance and swap decision
    always_comb begin
        state_next = state;
        latch_next = commit_latched;
        cnt_next   = cnt;
        sel_next   = sel_q;
        do_swap    = 1'b0;
        do_wr      = 1'b0;
        wr_reject  = 1'b0;

        case (state)
            S_IDLE: begin
                // A commit arriving with frame_start only arms; the swap waits for the next frame
                if (preset_load) begin
                    state_next = S_PRELOAD;
                    cnt_next   = 4'd0;
                    sel_next   = preset_sel;
                    latch_next = commit;
                end else if (commit) begin
                    state_next = S_ARMED;
                end
            end
            S_PRELOAD: begin
                // frame_start is ignored here so a half-loaded shadow is never applied
                if (commit)
                    latch_next = 1'b1;
                if (cnt == 4'd8) begin
                    state_next = (commit_latched || commit) ? S_ARMED : S_IDLE;
                    latch_next = 1'b0;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            S_ARMED: begin
                // Reloading a preset keeps the commit; it carries through PRELOAD in the latch
                if (preset_load) begin
                    state_next = S_PRELOAD;
                    cnt_next   = 4'd0;
                    sel_next   = preset_sel;
                    latch_next = 1'b1;
                end else if (frame_start) begin
                    state_next = S_IDLE;
                    do_swap    = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                latch_next = 1'b0;
                cnt_next   = 4'd0;
            end
        endcase

        // preset_load outranks a host write in the same cycle
        if (wr_en) begin
            if (state == S_PRELOAD || preset_load || wr_addr > 4'd8)
                wr_reject = 1'b1;
            else
                do_wr = 1'b1;
        end
    end

    // Coefficient banks and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                shadow[i]   <= preset_word(2'd0, 4'(i));
                cc_coeff[i] <= preset_word(2'd0, 4'(i));
            end
            busy      <= 1'b0;
            pending   <= 1'b0;
            swap_done <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            busy      <= (state_next == S_PRELOAD);
            pending   <= (state_next == S_ARMED) || latch_next;
            swap_done <= do_swap;
            wr_err    <= wr_reject;
            // Active takes the pre-write shadow when a write shares the swap cycle
            if (do_swap)
                cc_coeff <= shadow;
            if (state == S_PRELOAD)
                shadow[cnt] <= preset_word(sel_q, cnt);
            if (do_wr)
                shadow[wr_addr] <= wr_data;
        end
    end

`ifdef CCM_READBACK_EN
    // Registered readback of the active bank; out-of-range indices read as zero
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_addr <= 4'd8)
            rd_data <= cc_coeff[rd_addr];
        else
            rd_data <= '0;
    end
`endif

endmodule

// File: tb/tb_ccm_coeff_ctrl.sv
// tb/tb_ccm_coeff_ctrl.sv - scoreboard bench for ccm_coeff_ctrl
module tb_ccm_coeff_ctrl;

    localparam int W = 12;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               wr_en = 1'b0;
    logic [3:0]         wr_addr = '0;
    logic [W-1:0]       wr_data = '0;
    logic               commit = 1'b0;
    logic               frame_start = 1'b0;
    logic               preset_load = 1'b0;
    logic [1:0]         preset_sel = '0;
    logic [8:0][W-1:0]  cc_coeff;
    logic               busy, pending, swap_done, wr_err;
`ifdef CCM_READBACK_EN
    logic [3:0]         rd_addr = '0;
    logic [W-1:0]       rd_data;
`endif

    ccm_coeff_ctrl #(.INT_BITS(6), .FRAC_BITS(6)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .frame_start(frame_start), .preset_load(preset_load),
        .preset_sel(preset_sel), .cc_coeff(cc_coeff), .busy(busy), .pending(pending),
        .swap_done(swap_done), .wr_err(wr_err)
`ifdef CCM_READBACK_EN
        , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         swap;
        logic         err;
        logic         busy;
        logic         pending;
        logic [107:0] act;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    logic [W-1:0] m_shadow[9];
    logic [W-1:0] m_active[9];
    int           m_left = 0;
    int           m_sel = 0;
    logic         m_armed = 1'b0;

    function automatic logic [W-1:0] preset_val(input int sel, input int idx);
        case (sel)
            0: return (idx == 2 || idx == 4 || idx == 6) ? 12'd64 : 12'd0;
            1: return (idx % 3 == 0) ? 12'd7 : ((idx % 3 == 1) ? 12'd38 : 12'd19);
            2: return (idx == 0 || idx == 4 || idx == 8) ? 12'd64 : 12'd0;
            default: return 12'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // One clock of stimulus; the model advances to the state after the coming edge
    task automatic cyc(input logic we, input logic [3:0] wa, input logic [W-1:0] wd,
                       input logic cm, input logic fs, input logic pl, input logic [1:0] ps,
                       input logic rs);
        exp_t e;
        int   idx;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; commit = cm;
        frame_start = fs; preset_load = pl; preset_sel = ps; reset = rs;
        e.swap = 1'b0;
        e.err  = 1'b0;
        if (rs) begin
            for (int i = 0; i < 9; i++) begin
                m_shadow[i] = preset_val(0, i);
                m_active[i] = preset_val(0, i);
            end
            m_left  = 0;
            m_armed = 1'b0;
        end else if (m_left > 0) begin
            idx = 9 - m_left;
            m_shadow[idx] = preset_val(m_sel, idx);
            m_left--;
            if (we) e.err = 1'b1;
            if (cm) m_armed = 1'b1;
        end else if (pl) begin
            m_left = 9;
            m_sel  = int'(ps);
            if (cm) m_armed = 1'b1;
            if (we) e.err = 1'b1;
        end else begin
            if (m_armed && fs) begin
                m_active = m_shadow;
                m_armed  = 1'b0;
                e.swap   = 1'b1;
            end else if (cm) begin
                m_armed = 1'b1;
            end
            if (we) begin
                if (wa <= 4'd8) m_shadow[wa] = wd;
                else e.err = 1'b1;
            end
        end
        e.busy    = (m_left > 0);
        e.pending = m_armed;
        for (int i = 0; i < 9; i++) e.act[i*12 +: 12] = m_active[i];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: each edge with an issued expectation is compared against the outputs
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("swap_done", 128'(swap_done), 128'(e.swap));
            chk("wr_err",    128'(wr_err),    128'(e.err));
            chk("busy",      128'(busy),      128'(e.busy));
            chk("pending",   128'(pending),   128'(e.pending));
            chk("cc_coeff",  128'(cc_coeff),  128'(e.act));
        end
    end

    initial begin
        // Reset then quiet: identity active, nothing busy or pending
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Write idx0 = -32, commit, frame_start five cycles later
        cyc(1, 4'd0, 12'hFE0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        idle(4);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        idle(3);

        // Gray preset with commit; frame_start mid-load is ignored
        cyc(0, 0, 0, 1, 0, 1, 2'd1, 0);
        idle(3);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        idle(6);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // Rejected writes: out-of-range address and write during preload
        cyc(1, 4'd9, 12'h123, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 1, 2'd2, 0);
        idle(2);
        cyc(1, 4'd3, 12'h055, 0, 0, 0, 0, 0);
        idle(8);

        // Write on the swap cycle lands in shadow only
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        cyc(1, 4'd4, 12'd100, 0, 1, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // Commit and frame_start together in idle only arms
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);

        // Reset mid-preload with a latched commit
        cyc(0, 0, 0, 1, 0, 1, 2'd3, 0);
        idle(3);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) == 0, 4'($urandom % 11), 12'($urandom),
                ($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 25) == 0,
                2'($urandom), ($urandom % 300) == 0);
        end
        idle(12);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ccm_coeff_ctrl.md
Name: ccm_coeff_ctrl

Overview:
Configuration controller for the colorspace conversion stage. It owns the 3x3 colour-correction coefficient matrix, holding a host-writable shadow bank and an active bank that drives cc_coeff. A sequenced preset loader fills the shadow bank from built-in matrices. Shadow-to-active commits happen only on a frame boundary, so the matrix never changes mid-frame.

Parameters:
INT_BITS, 6, integer bits of each signed coefficient
FRAC_BITS, 6, fractional bits of each signed coefficient; W = INT_BITS+FRAC_BITS

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  single-cycle shadow write strobe
wr_addr  in  4  coefficient index 0..8
wr_data  in  W  signed coefficient value
commit  in  1  pulse; request shadow->active copy at next frame_start
frame_start  in  1  pulse on first pixel cycle of a frame
preset_load  in  1  pulse; start sequenced load of preset into shadow
preset_sel  in  2  preset index, sampled with preset_load
cc_coeff  out  9xW  signed active matrix, packed [8:0][W-1:0]
busy  out  1  high while preset load runs
pending  out  1  commit accepted, swap not yet done
swap_done  out  1  one-cycle pulse; new cc_coeff valid this cycle
wr_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high. Clock port is clk; reset port is reset.
- Index map: row r (0=red out, 1=green out, 2=blue out) uses cc_coeff[3r+2]·red + [3r+1]·green + [3r]·blue.
- Preset values are round(x·2^FRAC_BITS). Defaults shown for FRAC_BITS=6:
  - Preset 0, identity: idx 2,4,6 = 64; all others 0.
  - Preset 1, gray: every row {idx 3r = 7, 3r+1 = 38, 3r+2 = 19}.
  - Preset 2, R/B swap: idx 0,4,8 = 64; all others 0.
  - Preset 3, all zero.
- Reset values: active = shadow = identity. State IDLE. busy, pending, swap_done, wr_err all 0. All outputs are registered.
- States:
  - IDLE: accepts writes, commit and preset_load.
  - PRELOAD: a 4-bit counter 0..8 writes preset[sel][cnt] into shadow[cnt], one word per cycle, for exactly 9 cycles. busy=1 from the cycle after preset_load through the last write. Then go to ARMED if a commit is latched, else IDLE.
  - ARMED: pending=1. Writes and preset_load are still accepted.
- Writes:
  - In IDLE or ARMED, wr_addr <= 8 writes shadow[wr_addr]; the value is visible in shadow on the next cycle.
  - wr_addr > 8, or any wr_en during PRELOAD, pulses wr_err for one cycle the next cycle, and shadow is unchanged.
- Commit:
  - commit in IDLE: go to ARMED; pending rises next cycle.
  - commit in PRELOAD: latched; pending rises next cycle.
  - commit in ARMED: no effect.
- Swap:
  - frame_start in ARMED with no PRELOAD active: active <= shadow, state -> IDLE, pending -> 0.
  - swap_done pulses in the cycle the new cc_coeff is first driven, i.e. frame_start + 1.
  - frame_start in IDLE or PRELOAD is ignored. A latched commit is never applied to a partially loaded shadow.
- Simultaneous events:
  - preset_load and wr_en in the same cycle: preset wins; the write is rejected with wr_err.
  - preset_load in ARMED: go to PRELOAD and retain the commit.
  - wr_en on the swap cycle: the write lands in shadow only; active receives the pre-write shadow.
  - commit and frame_start in IDLE in the same cycle: arm only; swap on the next frame_start.
- Reset mid-PRELOAD or mid-ARMED: immediately returns to reset values; the latched commit is discarded.

Optional Feature:
CCM_READBACK_EN:
- Defined: adds rd_addr (in, 4) and rd_data (out, W), plus 1 extra cycle of registered latency.
  - rd_data returns active[rd_addr], or 0 when rd_addr > 8.
  - rd_data resets to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset deasserted, no stimulus -> cc_coeff[2]=cc_coeff[4]=cc_coeff[6]=64, others 0; busy=pending=0.
- Write idx 0 = -32 (0xFE0), commit, frame_start 5 cycles later -> pending=1 until the swap; at frame_start+1, cc_coeff[0]=0xFE0 and swap_done=1 for exactly 1 cycle.
- preset_load with sel=1 plus commit in the same cycle, and frame_start during cycle 4 of the load -> no swap and busy=1 for 9 cycles; next frame_start after the load -> gray matrix active (idx 3r=7, 3r+1=38, 3r+2=19).
- wr_en with addr 9, and wr_en during PRELOAD -> wr_err pulses once each; shadow and active are unchanged.
- Armed commit, wr_en idx 4 = 100 on the same cycle as frame_start -> active idx 4 keeps the old shadow value; after a second commit and frame_start, idx 4 = 100.
- Reset asserted for 1 cycle mid-PRELOAD with a commit latched -> identity restored, pending=0; the following frame_start causes no swap.
